// File: rtl/adder_cla_pipe.sv
// Pipelined CLA adder/subtractor: STG registered carry segments of BW-bit lookahead groups, latency STG.
// Global-enable pipeline: a held result (o_valid & ~i_ready) freezes every stage and drops o_ready.
module adder_cla_pipe #(
  parameter int DW  = 32,
  parameter int BW  = 4,
  parameter int STG = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_A,
  input  logic [DW-1:0] i_B,
  input  logic          i_Cin,
  input  logic          i_sub,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_S,
  output logic          o_Cout,
  output logic          o_V,
  output logic          o_Z
);

  localparam int SW = DW / STG;
  localparam int NG = SW / BW;

  if (STG < 1 || (DW % (STG * BW)) != 0) begin : g_param_check
    $error("adder_cla_pipe: need STG >= 1 and DW divisible by STG*BW");
  end

  // Index k of each array is the input side of stage k; index STG is the pipeline output.
  logic [DW-1:0] a_st   [STG];
  logic [DW-1:0] b_st   [STG];
  logic [DW-1:0] s_st   [STG+1];
  logic          c_st   [STG+1];
  logic          vld_st [STG+1];
  logic          cmsb_q;
  logic          adv;

  assign adv       = ~vld_st[STG] | i_ready;
  assign o_ready   = adv;

  assign a_st[0]   = i_A;
  assign b_st[0]   = i_sub ? ~i_B : i_B;
  assign c_st[0]   = i_sub | i_Cin;
  assign s_st[0]   = '0;
  assign vld_st[0] = i_valid;

  for (genvar k = 0; k < STG; k++) begin : g_stage
    logic [SW-1:0] a_sl, b_sl, g, p, c;
    logic [DW-1:0] s_nxt, s_q;
    logic          cout, c_q, vld_q;
    logic          cg, cr, gg, pp;

    assign a_sl = a_st[k][k*SW +: SW];
    assign b_sl = b_st[k][k*SW +: SW];
    assign g    = a_sl & b_sl;
    assign p    = a_sl ^ b_sl;

    // Group G/P resolves each group's carry-out in one level; bit carries ripple inside the group.
    always_comb begin
      c  = '0;
      cg = c_st[k];
      cr = 1'b0;
      gg = 1'b0;
      pp = 1'b0;
      for (int j = 0; j < NG; j++) begin
        cr = cg;
        gg = 1'b0;
        pp = 1'b1;
        for (int i = 0; i < BW; i++) begin
          c[j*BW+i] = cr;
          cr = g[j*BW+i] | (p[j*BW+i] & cr);
          gg = g[j*BW+i] | (p[j*BW+i] & gg);
          pp = pp & p[j*BW+i];
        end
        cg = gg | (pp & cg);
      end
      cout = cg;
    end

    always_comb begin
      s_nxt = s_st[k];
      s_nxt[k*SW +: SW] = p ^ c;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        vld_q <= 1'b0;
        s_q   <= '0;
        c_q   <= 1'b0;
      end else if (adv) begin
        vld_q <= vld_st[k];
        s_q   <= s_nxt;
        c_q   <= cout;
      end
    end

    assign vld_st[k+1] = vld_q;
    assign s_st[k+1]   = s_q;
    assign c_st[k+1]   = c_q;

    if (k < STG - 1) begin : g_pass
      logic [DW-1:0] a_q, b_q;
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_st[k];
          b_q <= b_st[k];
        end
      end
      assign a_st[k+1] = a_q;
      assign b_st[k+1] = b_q;
    end else begin : g_last
      // Carry into the MSB is kept so overflow can be formed from registered values.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)    cmsb_q <= 1'b0;
        else if (adv) cmsb_q <= c[SW-1];
      end
    end
  end

  assign o_valid = vld_st[STG];
  assign o_S     = s_st[STG];
  assign o_Cout  = c_st[STG];
  assign o_V     = cmsb_q ^ c_st[STG];
  assign o_Z     = (s_st[STG] == '0);

endmodule

// File: tb/tb_adder_cla_pipe.sv
// Self-checking bench for adder_cla_pipe: directed vectors, streaming, stall, reset and random traffic.
`timescale 1ns/1ps
module tb_adder_cla_pipe;
  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int STG = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid, o_ready, i_Cin, i_sub, o_valid, i_ready;
  logic          o_Cout, o_V, o_Z;
  logic [DW-1:0] i_A, i_B, o_S;

  typedef struct packed {
    logic          z;
    logic          v;
    logic          c;
    logic [DW-1:0] s;
  } res_t;

  res_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  adder_cla_pipe #(.DW(DW), .BW(BW), .STG(STG)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_A    (i_A),
    .i_B    (i_B),
    .i_Cin  (i_Cin),
    .i_sub  (i_sub),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_S    (o_S),
    .o_Cout (o_Cout),
    .o_V    (o_V),
    .o_Z    (o_Z)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic cin, input logic sub);
    res_t          r;
    logic [DW-1:0] be;
    logic [DW:0]   full;
    be   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, be} + {{DW{1'b0}}, (sub | cin)};
    r.s  = full[DW-1:0];
    r.c  = full[DW];
    r.v  = (a[DW-1] == be[DW-1]) && (r.s[DW-1] != a[DW-1]);
    r.z  = (r.s == '0);
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_op();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < DW; i += 32) r = (r << 32) | DW'($urandom);
    case ($urandom_range(0, 5))
      0:       r = '0;
      1:       r = '1;
      2:       r = {1'b0, {(DW-1){1'b1}}};
      3:       r = {1'b1, {(DW-1){1'b0}}};
      default: ;
    endcase
    return r;
  endfunction

  task automatic drive_rnd();
    i_A   = rnd_op();
    i_B   = rnd_op();
    i_Cin = 1'($urandom_range(0, 1));
    i_sub = 1'($urandom_range(0, 1));
  endtask

  // One clock: handshakes are judged at the falling edge, then control returns just after the rising edge.
  task automatic cycle();
    res_t got;
    @(negedge clk);
    if (o_valid && i_ready) begin
      got = {o_Z, o_V, o_Cout, o_S};
      check("sb_occupancy", sb_q.size() != 0, 1'b1);
      if (sb_q.size() != 0) check("sb_result", got, sb_q.pop_front());
    end
    if (i_valid && o_ready) sb_q.push_back(model(i_A, i_B, i_Cin, i_sub));
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic cin, input logic sub, input logic [DW-1:0] es,
                         input logic ec, input logic ev, input logic ez);
    int lat;
    i_A = a; i_B = b; i_Cin = cin; i_sub = sub;
    i_valid = 1'b1;
    i_ready = 1'b1;
    cycle();
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 20) begin
      cycle();
      lat++;
    end
    check({tag, "_latency"}, lat, STG);
    check(tag, {o_Z, o_V, o_Cout, o_S}, {ez, ev, ec, es});
    cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] hold_s;
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_A = '0; i_B = '0; i_Cin = 1'b0; i_sub = 1'b0;
    #2;
    check("reset_valid", o_valid, 1'b0);
    check("reset_s",     o_S,     '0);
    check("reset_flags", {o_Cout, o_V, o_Z, o_ready}, 4'b0011);
    @(posedge clk); #1;
    rst = 1'b0;

    run_one("add_wrap",   32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1);
    run_one("add_ovf",    32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_one("sub_ovf",    32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_one("add_cin",    32'h0000_FFFF, 32'h0, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    run_one("sub_borrow", 32'h3,         32'h5, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

    // Eight back-to-back operations: results on consecutive cycles after the pipeline latency.
    i_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      i_valid = (t < 8);
      drive_rnd();
      cycle();
      check("stream_valid", o_valid, (t >= STG-1) && (t < STG-1+8));
    end

    // Fill against a blocked output, then hold for three cycles.
    i_ready = 1'b0;
    i_valid = 1'b1;
    for (int t = 0; t < STG; t++) begin
      drive_rnd();
      cycle();
    end
    check("stall_full_valid", o_valid, 1'b1);
    hold_s = o_S;
    for (int t = 0; t < 3; t++) begin
      check("stall_ready", o_ready, 1'b0);
      cycle();
      check("stall_s_stable", o_S, hold_s);
    end
    i_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      drive_rnd();
      cycle();
    end
    i_valid = 1'b0;
    for (int t = 0; t < STG + 2; t++) cycle();
    check("stall_drained", sb_q.size(), 0);

    // Reset with operations in flight and a valid result on the output.
    i_ready = 1'b1;
    for (int t = 0; t < STG; t++) begin
      i_valid = 1'b1;
      i_A = rnd_op() | 1;
      i_B = '0; i_Cin = 1'b0; i_sub = 1'b0;
      cycle();
    end
    check("rst_pre_valid", o_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_valid", o_valid, 1'b0);
    check("rst_s",     o_S,     '0);
    check("rst_flags", {o_Cout, o_V, o_Z, o_ready}, 4'b0011);
    sb_q.delete();
    i_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_one("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0);

    // Random traffic with random valid/ready, checked through the scoreboard.
    for (int t = 0; t < 3000; t++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 3) != 0);
      drive_rnd();
      cycle();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int t = 0; t < STG + 2; t++) cycle();
    check("rand_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
